regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised successor to the pipeline register file: NREAD synchronous read ports, one write port,
//  same-cycle write-to-read bypass, read-only constant registers and a per-register busy scoreboard.
//  Sits between decode and execute in pipe; decode reserves destinations, writeback releases them,
//  and rd_busy drives stall/hazard logic.
// PARAMETERS
//  WIDTH   16  data word width
//  ADDR_W  6   register address width; depth = 2**ADDR_W
//  NREAD   2   number of read ports
//  NCONST  4   registers 0..NCONST-1 are read-only constants (NCONST <= 4)
// PORTS
//  clk        in   1               clock; all state updates on posedge
//  reset      in   1               asynchronous, active-low reset
//  rd_en      in   1               sample all read ports this cycle
//  rd_addr    in   NREAD*ADDR_W    port i address = bits [i*ADDR_W +: ADDR_W]
//  rd_data    out  NREAD*WIDTH     port i data, registered
//  rd_busy    out  NREAD           port i register had a pending producer
//  rd_valid   out  1               rd_data/rd_busy updated by the previous edge
//  rsv_en     in   1               reserve (mark busy) rsv_addr
//  rsv_addr   in   ADDR_W          destination register being reserved
//  wr_en      in   1               write wr_data to wr_addr and release its busy bit
//  wr_addr    in   ADDR_W          write address
//  wr_data    in   WIDTH           write data
//  err_const  out  1               one-cycle pulse: write or reserve aimed at a constant register
//  busy_count out  ADDR_W+1        number of busy registers, registered
// BEHAVIOUR
//  Reset (reset=0, async):
//   - Constants: r0=0, r1=1, r2=16'h8000, r3=16'hffff (lowest NCONST entries; values WIDTH-truncated/zero-extended).
//   - All other registers = 0. All busy bits = 0.
//   - rd_data=0, rd_busy=0, rd_valid=0, err_const=0, busy_count=0.
//  Read (1-cycle latency):
//   - At a posedge with rd_en=1, each port i loads rd_data[i]:
//     - wr_data if wr_en=1, wr_addr==rd_addr[i] and wr_addr>=NCONST (bypass);
//     - otherwise regs[rd_addr[i]].
//   - rd_busy[i] <= busy[rd_addr[i]] & ~(wr_en & wr_addr==rd_addr[i]). A same-cycle rsv_en does not affect the read.
//   - rd_valid <= rd_en. With rd_en=0, rd_data and rd_busy hold their values.
//   - A constant address always reads its constant with rd_busy=0. Duplicate addresses across ports are legal.
//  Write:
//   - wr_en=1 and wr_addr>=NCONST: regs[wr_addr] <= wr_data and busy[wr_addr] cleared. Releasing a non-busy register is legal.
//   - wr_en=1 and wr_addr<NCONST: write ignored and err_const=1 next cycle.
//  Reserve:
//   - rsv_en=1 and rsv_addr>=NCONST: busy[rsv_addr] set. Reserving an already-busy register leaves it busy with no error.
//   - rsv_en=1 and rsv_addr<NCONST: ignored and err_const=1 next cycle.
//  Simultaneous events:
//   - rsv_en and wr_en to the same address: data is written and busy ends SET (new producer wins).
//  Scoreboard update rule:
//   - busy_next = (busy & ~clr) | set. busy_count <= popcount(busy_next), i.e. it is valid one cycle after the event.
//  err_const is the OR of both error causes and lasts exactly one cycle per offending edge.
//  Reset mid-operation clears the scoreboard and reinitialises registers immediately, regardless of clk. The first posedge after release behaves normally.
// TESTING
//  1. Release reset, rd_en=1, rd_addr={3,2} -> next cycle rd_data={16'hffff,16'h8000}, rd_busy=0, rd_valid=1.
//  2. Same cycle: wr r10=16'h1234 and read port0 r10 -> next cycle port0 reads 16'h1234 (bypass); a later read also gives 16'h1234.
//  3. Reserve r5 -> busy_count=1 and read r5 gives rd_busy[0]=1. Then wr r5=16'hbeef -> busy_count=0, and read r5 = 16'hbeef with rd_busy=0.
//  4. wr r1=16'h5555 and reserve r0 on separate cycles -> err_const=1 for exactly one cycle each; r1 still reads 16'h0001 and busy_count=0.
//  5. Same cycle: reserve r7 and wr r7=16'h00aa -> r7 reads 16'h00aa with rd_busy=1 and busy_count=1.
//  6. Reserve r9 and r12, then pull reset low between edges -> busy_count, rd_valid and rd_data are 0 immediately; r9 reads 0 after release.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Multi-port register file: synchronous reads with write bypass, read-only constants,
// and a per-register busy scoreboard with a registered population count.
module regfile_scoreboard #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 6,
  parameter int NREAD  = 2,
  parameter int NCONST = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rd_en,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*WIDTH-1:0]  rd_data,
  output logic [NREAD-1:0]        rd_busy,
  output logic                    rd_valid,
  input  logic                    rsv_en,
  input  logic [ADDR_W-1:0]       rsv_addr,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  output logic                    err_const,
  output logic [ADDR_W:0]         busy_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] CONST_LIM = ADDR_W'(NCONST);

  function automatic logic [WIDTH-1:0] const_val(input int idx);
    logic [31:0] v;
    case (idx)
      0:       v = 32'h0000_0000;
      1:       v = 32'h0000_0001;
      2:       v = 32'h0000_8000;
      3:       v = 32'h0000_ffff;
      default: v = 32'h0000_0000;
    endcase
    return WIDTH'(v);
  endfunction

  logic [WIDTH-1:0]       regs [DEPTH];
  logic [DEPTH-1:0]       busy;
  logic [DEPTH-1:0]       busy_next;
  logic [DEPTH-1:0]       set_vec;
  logic [DEPTH-1:0]       clr_vec;
  logic [ADDR_W:0]        count_next;
  logic [NREAD*WIDTH-1:0] rd_data_next;
  logic [NREAD-1:0]       rd_busy_next;
  logic                   wr_ok;
  logic                   rsv_ok;
  logic                   err_next;

  assign wr_ok    = wr_en  && (wr_addr  >= CONST_LIM);
  assign rsv_ok   = rsv_en && (rsv_addr >= CONST_LIM);
  assign err_next = (wr_en && !wr_ok) || (rsv_en && !rsv_ok);

  // Set is applied after clear so a same-cycle reserve beats the release.
  assign clr_vec   = wr_ok  ? (DEPTH'(1) << wr_addr)  : '0;
  assign set_vec   = rsv_ok ? (DEPTH'(1) << rsv_addr) : '0;
  assign busy_next = (busy & ~clr_vec) | set_vec;

  always_comb begin
    count_next = '0;
    for (int i = 0; i < DEPTH; i++)
      count_next = count_next + (ADDR_W+1)'(busy_next[ADDR_W'(i)]);
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit;
    assign addr = rd_addr[g*ADDR_W +: ADDR_W];
    assign hit  = wr_en && (wr_addr == addr);
    assign rd_data_next[g*WIDTH +: WIDTH] = (hit && wr_ok) ? wr_data : regs[addr];
    assign rd_busy_next[g] = busy[addr] & ~hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs[ADDR_W'(i)] <= (i < NCONST) ? const_val(i) : '0;
      busy       <= '0;
      busy_count <= '0;
      rd_data    <= '0;
      rd_busy    <= '0;
      rd_valid   <= 1'b0;
      err_const  <= 1'b0;
    end else begin
      if (wr_ok)
        regs[wr_addr] <= wr_data;
      busy       <= busy_next;
      busy_count <= count_next;
      rd_valid   <= rd_en;
      err_const  <= err_next;
      if (rd_en) begin
        rd_data <= rd_data_next;
        rd_busy <= rd_busy_next;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and randomized checks of regfile_scoreboard against an array-based
// behavioural model of the register file and its scoreboard.
module tb_regfile_scoreboard;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 6;
  localparam int NREAD  = 2;
  localparam int NCONST = 4;
  localparam int DEPTH  = 64;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    rd_en;
  logic [NREAD*ADDR_W-1:0] rd_addr;
  logic [NREAD*WIDTH-1:0]  rd_data;
  logic [NREAD-1:0]        rd_busy;
  logic                    rd_valid;
  logic                    rsv_en;
  logic [ADDR_W-1:0]       rsv_addr;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [WIDTH-1:0]        wr_data;
  logic                    err_const;
  logic [ADDR_W:0]         busy_count;

  regfile_scoreboard #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NREAD(NREAD), .NCONST(NCONST)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .rd_valid(rd_valid), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .err_const(err_const),
    .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [WIDTH-1:0] m_regs [DEPTH];
  bit               m_busy [DEPTH];
  logic [WIDTH-1:0] e_data [NREAD];
  logic             e_busy [NREAD];
  logic             e_valid;
  logic             e_err;
  int               e_count;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = 16'h0000;
      m_busy[i] = 1'b0;
    end
    m_regs[0] = 16'h0000;
    m_regs[1] = 16'h0001;
    m_regs[2] = 16'h8000;
    m_regs[3] = 16'hffff;
    for (int p = 0; p < NREAD; p++) begin
      e_data[p] = '0;
      e_busy[p] = 1'b0;
    end
    e_valid = 1'b0;
    e_err   = 1'b0;
    e_count = 0;
  endtask

  // Applies the current inputs to the model as one clock edge would.
  task automatic model_edge();
    int a;
    int wa;
    int ra;
    wa = int'(wr_addr);
    ra = int'(rsv_addr);
    e_err = (wr_en && wa < NCONST) || (rsv_en && ra < NCONST);
    e_valid = rd_en;
    if (rd_en) begin
      for (int p = 0; p < NREAD; p++) begin
        a = int'(rd_addr[p*ADDR_W +: ADDR_W]);
        if (wr_en && wa == a && a >= NCONST) e_data[p] = wr_data;
        else                                 e_data[p] = m_regs[a];
        e_busy[p] = m_busy[a] && !(wr_en && wa == a);
      end
    end
    if (wr_en && wa >= NCONST) begin
      m_regs[wa] = wr_data;
      m_busy[wa] = 1'b0;
    end
    if (rsv_en && ra >= NCONST) m_busy[ra] = 1'b1;
    e_count = 0;
    for (int i = 0; i < DEPTH; i++) e_count += int'(m_busy[i]);
  endtask

  task automatic check_all(input string tag);
    n_vec++;
    assert (rd_valid === e_valid) else begin
      n_miss++;
      $error("FAIL %s rd_valid observed %b expected %b", tag, rd_valid, e_valid);
    end
    for (int p = 0; p < NREAD; p++) begin
      assert (rd_data[p*WIDTH +: WIDTH] === e_data[p]) else begin
        n_miss++;
        $error("FAIL %s rd_data[%0d] observed %h expected %h", tag, p, rd_data[p*WIDTH +: WIDTH], e_data[p]);
      end
      assert (rd_busy[p] === e_busy[p]) else begin
        n_miss++;
        $error("FAIL %s rd_busy[%0d] observed %b expected %b", tag, p, rd_busy[p], e_busy[p]);
      end
    end
    assert (err_const === e_err) else begin
      n_miss++;
      $error("FAIL %s err_const observed %b expected %b", tag, err_const, e_err);
    end
    assert (int'(busy_count) === e_count) else begin
      n_miss++;
      $error("FAIL %s busy_count observed %0d expected %0d", tag, busy_count, e_count);
    end
  endtask

  task automatic idle();
    rd_en = 1'b0; rd_addr = '0;
    rsv_en = 1'b0; rsv_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic set_rd(input int a1, input int a0);
    rd_en = 1'b1;
    rd_addr = {ADDR_W'(a1), ADDR_W'(a0)};
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: constant read
    set_rd(3, 2);
    step("const_read");

    // 2: bypass then plain read
    wr_en = 1'b1; wr_addr = 10; wr_data = 16'h1234; set_rd(0, 10);
    step("bypass");
    set_rd(10, 10);
    step("read_after_wr");

    // 3: reserve and release
    rsv_en = 1'b1; rsv_addr = 5;
    step("reserve_r5");
    set_rd(3, 5);
    step("read_busy_r5");
    wr_en = 1'b1; wr_addr = 5; wr_data = 16'hbeef;
    step("release_r5");
    set_rd(0, 5);
    step("read_r5");

    // 4: constant write / reserve errors
    wr_en = 1'b1; wr_addr = 1; wr_data = 16'h5555;
    step("err_wr_const");
    step("err_clear1");
    rsv_en = 1'b1; rsv_addr = 0;
    step("err_rsv_const");
    set_rd(0, 1);
    step("const_r1_kept");

    // 5: reserve and write same register same cycle
    rsv_en = 1'b1; rsv_addr = 7; wr_en = 1'b1; wr_addr = 7; wr_data = 16'h00aa;
    step("rsv_wr_same");
    set_rd(7, 7);
    step("read_r7");

    // randomized traffic over a small address window to force collisions
    for (int n = 0; n < 400; n++) begin
      rd_en    = ($urandom_range(0, 3) != 0);
      rd_addr  = {ADDR_W'($urandom_range(0, 15)), ADDR_W'($urandom_range(0, 15))};
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = ADDR_W'($urandom_range(0, 15));
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_addr  = ADDR_W'($urandom_range(0, 15));
      wr_data  = WIDTH'($urandom);
      step("random");
    end

    // 6: async reset mid-operation
    rsv_en = 1'b1; rsv_addr = 9;
    step("reserve_r9");
    rsv_en = 1'b1; rsv_addr = 12; set_rd(12, 9);
    step("reserve_r12");
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clk);
    reset = 1'b1;
    set_rd(12, 9);
    step("read_r9_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
